// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cpu_pkg                                                      |
// | Description : Shared constants for the CPU program loader: instruction     |
// |               width, instruction-memory address width, loader state        |
// |               encoding and error codes.                                    |
// |               Optional feature macro: PROG_LOADER_CSUM_EN (adds ST_CSUM).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cpu_pkg;

   localparam int INSTR_W     = 19;
   localparam int IMEM_ADDR_W = 8;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LEN_HI = 4'd1,
      ST_LEN_LO = 4'd2,
      ST_B0     = 4'd3,
      ST_B1     = 4'd4,
      ST_B2     = 4'd5,
`ifdef PROG_LOADER_CSUM_EN
      ST_CSUM   = 4'd6,
`endif
      ST_DONE   = 4'd7,
      ST_ERROR  = 4'd8
   } loader_state_t;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_FORMAT = 2'd1;
   localparam logic [1:0] ERR_LENGTH = 2'd2;
   localparam logic [1:0] ERR_CSUM   = 2'd3;   // also used for abort

   // A session is in progress in every state except the three resting ones.
   function automatic logic is_busy(input loader_state_t s);
      return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR));
   endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : prog_loader_if                                               |
// | Description : Byte-stream input and instruction-memory write bus of the    |
// |               program loader.                                              |
// |   in_valid/in_data/in_ready : byte stream, transfer on valid && ready      |
// |   mem_we/mem_addr/mem_wdata : one-cycle instruction-memory write strobe    |
// |   modport master : loader side (consumes bytes, drives memory writes)      |
// |   modport slave  : environment side (supplies bytes, observes writes)      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface prog_loader_if #(
   parameter int ADDR_W  = cpu_pkg::IMEM_ADDR_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W
);
   logic               in_valid;
   logic [7:0]         in_data;
   logic               in_ready;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [INSTR_W-1:0] mem_wdata;

   modport master (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/instr_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_packer                                                 |
// | Description : Collects the three bytes of one instruction, checks that the |
// |               first byte only uses bits 2:0, and emits the 19-bit word     |
// |               with a one-cycle word_valid pulse after the third byte.      |
// |   clk, reset  : clock, asynchronous active-high reset                      |
// |   byte_valid  : a byte of an instruction is being accepted                 |
// |   byte_idx    : 0/1/2 position of that byte within the instruction         |
// |   byte_data   : the byte                                                   |
// |   kill        : suppress capture (abort in progress)                       |
// |   format_err  : first byte has bits 7:3 set (combinational)                |
// |   word        : packed instruction {b0[2:0], b1, b2}                       |
// |   word_valid  : one-cycle pulse, word is new                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_packer
   import cpu_pkg::*;
(
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic               byte_valid,
   input  wire logic [1:0]         byte_idx,
   input  wire logic [7:0]         byte_data,
   input  wire logic               kill,
   output logic                    format_err,
   output logic [INSTR_W-1:0]      word,
   output logic                    word_valid
);

   logic [2:0] r_b0;
   logic [7:0] r_b1;

   assign format_err = byte_valid && (byte_idx == 2'd0) && (byte_data[7:3] != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_b0       <= 3'd0;
         r_b1       <= 8'd0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (byte_valid && !kill && !format_err) begin
            case (byte_idx)
               2'd0: r_b0 <= byte_data[2:0];
               2'd1: r_b1 <= byte_data;
               2'd2: begin
                  word       <= {r_b0, r_b1, byte_data};
                  word_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prog_loader                                                  |
// | Description : Loads a CPU program from a byte stream into instruction      |
// |               memory while holding the CPU in reset. Stream format:        |
// |               LEN_HI, LEN_LO (word count N), N x 3 instruction bytes,      |
// |               and a checksum byte when PROG_LOADER_CSUM_EN is defined      |
// |               (running XOR of every byte from LEN_HI to the last B2).      |
// |   clk, reset : clock, asynchronous active-high reset                       |
// |   start      : one-cycle pulse, begins a session from IDLE/DONE/ERROR      |
// |   abort      : ends a busy session with err_code 3                         |
// |   bus        : byte stream in, instruction-memory writes out               |
// |   cpu_hold   : high while a session is in progress                         |
// |   done/error : level status of the last session                            |
// |   err_code   : 0 none, 1 bad format, 2 length overflow, 3 checksum/abort   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prog_loader #(
   parameter int ADDR_W  = cpu_pkg::IMEM_ADDR_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W
) (
   input  wire logic     clk,
   input  wire logic     reset,
   input  wire logic     start,
   input  wire logic     abort,
   prog_loader_if.master bus,
   output logic          cpu_hold,
   output logic          done,
   output logic          error,
   output logic [1:0]    err_code
);
   import cpu_pkg::*;

   localparam logic [16:0]     MAX_WORDS = 17'(2**ADDR_W);
   localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

`ifdef PROG_LOADER_CSUM_EN
   localparam loader_state_t   ST_FINAL  = ST_CSUM;
`else
   localparam loader_state_t   ST_FINAL  = ST_DONE;
`endif

   loader_state_t      state, state_nx;
   logic [7:0]         r_len_hi;
   logic [ADDR_W:0]    r_len;
   logic [ADDR_W:0]    r_count;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [1:0]         r_err_code, w_err_nx;
   logic               r_done, r_error;

   logic               w_busy, w_accept, w_clear, w_last, w_wr_accept;
   logic               w_byte_valid, w_format_err, w_word_valid;
   logic [1:0]         w_byte_idx;
   logic [15:0]        w_len_in;
   logic [INSTR_W-1:0] w_word;

   assign w_busy      = is_busy(state);
   assign w_accept    = bus.in_valid && w_busy;
   assign w_len_in    = {r_len_hi, bus.in_data};
   assign w_last      = ((r_count + ONE) == r_len);
   // Abort beats a coinciding B2 acceptance, so no write is launched then.
   assign w_wr_accept = w_accept && (state == ST_B2) && !abort;

   assign bus.in_ready  = w_busy;
   assign bus.mem_we    = w_word_valid;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = w_word;
   assign cpu_hold      = w_busy;
   assign done          = r_done;
   assign error         = r_error;
   assign err_code      = r_err_code;

`ifdef PROG_LOADER_CSUM_EN
   logic [7:0] r_csum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_csum <= 8'd0;
      end else if (w_clear) begin
         r_csum <= 8'd0;
      end else if (w_accept && !abort && (state != ST_CSUM)) begin
         r_csum <= r_csum ^ bus.in_data;
      end
   end
`endif

   always_comb begin
      w_byte_idx = 2'd3;
      case (state)
         ST_B0:   w_byte_idx = 2'd0;
         ST_B1:   w_byte_idx = 2'd1;
         ST_B2:   w_byte_idx = 2'd2;
         default: w_byte_idx = 2'd3;
      endcase
   end

   assign w_byte_valid = w_accept && (w_byte_idx != 2'd3);

   instr_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (w_byte_valid),
      .byte_idx   (w_byte_idx),
      .byte_data  (bus.in_data),
      .kill       (abort),
      .format_err (w_format_err),
      .word       (w_word),
      .word_valid (w_word_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      w_err_nx = r_err_code;
      w_clear  = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_nx = ST_LEN_HI;
               w_clear  = 1'b1;
               w_err_nx = ERR_NONE;
            end
         end
         ST_LEN_HI: if (w_accept) state_nx = ST_LEN_LO;
         ST_LEN_LO: begin
            if (w_accept) begin
               if (w_len_in == 16'd0) begin
                  state_nx = ST_FINAL;
               end else if ({1'b0, w_len_in} > MAX_WORDS) begin
                  state_nx = ST_ERROR;
                  w_err_nx = ERR_LENGTH;
               end else begin
                  state_nx = ST_B0;
               end
            end
         end
         ST_B0: begin
            if (w_accept) begin
               if (w_format_err) begin
                  state_nx = ST_ERROR;
                  w_err_nx = ERR_FORMAT;
               end else begin
                  state_nx = ST_B1;
               end
            end
         end
         ST_B1: if (w_accept) state_nx = ST_B2;
         // The decision uses the pre-increment count so the next B0 can be
         // accepted in the same cycle the write is presented.
         ST_B2: if (w_accept) state_nx = w_last ? ST_FINAL : ST_B0;
`ifdef PROG_LOADER_CSUM_EN
         ST_CSUM: begin
            if (w_accept) begin
               if (bus.in_data == r_csum) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx = ST_ERROR;
                  w_err_nx = ERR_CSUM;
               end
            end
         end
`endif
         default: state_nx = ST_IDLE;
      endcase

      if (abort && w_busy) begin
         state_nx = ST_ERROR;
         w_err_nx = ERR_CSUM;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_len_hi   <= 8'd0;
         r_len      <= '0;
         r_count    <= '0;
         r_mem_addr <= '0;
         r_err_code <= ERR_NONE;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_err_code <= w_err_nx;
         r_done     <= (state_nx == ST_DONE);
         r_error    <= (state_nx == ST_ERROR);
         if (w_clear) begin
            r_count <= '0;
            r_len   <= '0;
         end else begin
            if (w_accept && (state == ST_LEN_HI)) r_len_hi <= bus.in_data;
            if (w_accept && (state == ST_LEN_LO)) r_len    <= w_len_in[ADDR_W:0];
            if (w_wr_accept) begin
               r_mem_addr <= r_count[ADDR_W-1:0];
               r_count    <= r_count + ONE;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_prog_loader                                               |
// | Description : Directed self-checking bench for prog_loader. Drives byte   |
// |               streams on the falling edge, logs memory writes on the       |
// |               falling edge and compares against hand-computed values.      |
// |               Follows PROG_LOADER_CSUM_EN to append checksum bytes.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       cpu_hold, done, error;
   logic [1:0] err_code;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  tb_csum = 8'd0;
   logic [7:0]  log_addr [0:1023];
   logic [18:0] log_data [0:1023];
   int          wr_n = 0;

   prog_loader_if #(.ADDR_W(8), .INSTR_W(19)) bus ();

   prog_loader #(.ADDR_W(8), .INSTR_W(19)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1 && wr_n < 1024) begin
         log_addr[wr_n] = bus.mem_addr;
         log_data[wr_n] = bus.mem_wdata;
         wr_n = wr_n + 1;
      end
   end

   task automatic do_start();
      @(negedge clk);
      start   = 1'b1;
      tb_csum = 8'd0;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic ab = 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      abort        = ab;
      tb_csum      = tb_csum ^ b;
   endtask

   task automatic finish_stream();
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      abort        = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (bus.in_ready !== 1'b0)  begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (bus.mem_we !== 1'b0)    begin n_errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
      n_checks++; if (bus.mem_addr !== 8'h00) begin n_errors++; $display("FAIL reset_mem_addr: got %h want 00", bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== 19'h0) begin n_errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
      n_checks++; if (cpu_hold !== 1'b0)      begin n_errors++; $display("FAIL reset_cpu_hold: got %b want 0", cpu_hold); end
      n_checks++; if ({done, error, err_code} !== 4'b0000) begin n_errors++; $display("FAIL reset_status: got %b want 0000", {done, error, err_code}); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_two_words();
      int base;
      base = wr_n;
      do_start();
      #1;
      n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL two_hold_high: got %b want 1", cpu_hold); end
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
      send_byte(8'h07);
      // First write is presented while the next B0 byte is offered.
      n_checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h00, 19'h12345})
         begin n_errors++; $display("FAIL two_overlap_write: got %b/%h/%h want 1/00/12345", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      send_byte(8'hFF); send_byte(8'hFF);
`ifdef PROG_LOADER_CSUM_EN
      // Running XOR of this stream is 0x62.
      send_byte(8'h62);
`endif
      finish_stream();
      n_checks++; if (wr_n - base !== 2) begin n_errors++; $display("FAIL two_write_count: got %0d want 2", wr_n - base); end
      n_checks++; if ({log_addr[base], log_data[base]} !== {8'h00, 19'h12345})
         begin n_errors++; $display("FAIL two_word0: got %h/%h want 00/12345", log_addr[base], log_data[base]); end
      n_checks++; if ({log_addr[base+1], log_data[base+1]} !== {8'h01, 19'h7FFFF})
         begin n_errors++; $display("FAIL two_word1: got %h/%h want 01/7ffff", log_addr[base+1], log_data[base+1]); end
      n_checks++; if ({done, error, err_code} !== 4'b1000) begin n_errors++; $display("FAIL two_status: got %b want 1000", {done, error, err_code}); end
      n_checks++; if ({cpu_hold, bus.in_ready} !== 2'b00) begin n_errors++; $display("FAIL two_hold_released: got %b want 00", {cpu_hold, bus.in_ready}); end
   endtask

   task automatic test_abort_idle();
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      #1;
      n_checks++; if ({done, error, err_code, cpu_hold} !== 5'b10000) begin n_errors++; $display("FAIL abort_idle: got %b want 10000", {done, error, err_code, cpu_hold}); end
   endtask

   task automatic test_len_overflow();
      int base;
      base = wr_n;
      do_start();
      send_byte(8'h01); send_byte(8'h01);
      finish_stream();
      n_checks++; if ({done, error, err_code} !== 4'b0110) begin n_errors++; $display("FAIL overflow_status: got %b want 0110", {done, error, err_code}); end
      n_checks++; if (wr_n - base !== 0) begin n_errors++; $display("FAIL overflow_writes: got %0d want 0", wr_n - base); end
      n_checks++; if ({cpu_hold, bus.in_ready} !== 2'b00) begin n_errors++; $display("FAIL overflow_hold: got %b want 00", {cpu_hold, bus.in_ready}); end
   endtask

   task automatic test_empty();
      int base;
      base = wr_n;
      do_start();
      #1;
      n_checks++; if ({done, error, err_code, cpu_hold} !== 5'b00001) begin n_errors++; $display("FAIL restart_clears: got %b want 00001", {done, error, err_code, cpu_hold}); end
      send_byte(8'h00); send_byte(8'h00);
`ifdef PROG_LOADER_CSUM_EN
      send_byte(8'h00);
`endif
      finish_stream();
      n_checks++; if (wr_n - base !== 0) begin n_errors++; $display("FAIL empty_writes: got %0d want 0", wr_n - base); end
      n_checks++; if ({done, error, err_code} !== 4'b1000) begin n_errors++; $display("FAIL empty_status: got %b want 1000", {done, error, err_code}); end
   endtask

   task automatic test_bad_format();
      int base;
      base = wr_n;
      do_start();
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h08);
      finish_stream();
      n_checks++; if ({done, error, err_code} !== 4'b0101) begin n_errors++; $display("FAIL format_status: got %b want 0101", {done, error, err_code}); end
      n_checks++; if (wr_n - base !== 0) begin n_errors++; $display("FAIL format_writes: got %0d want 0", wr_n - base); end
   endtask

   task automatic test_abort();
      int base;
      base = wr_n;
      do_start();
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
      send_byte(8'h02, 1'b1);
      finish_stream();
      n_checks++; if (wr_n - base !== 1) begin n_errors++; $display("FAIL abort_write_count: got %0d want 1", wr_n - base); end
      n_checks++; if ({log_addr[base], log_data[base]} !== {8'h00, 19'h12345})
         begin n_errors++; $display("FAIL abort_word0: got %h/%h want 00/12345", log_addr[base], log_data[base]); end
      n_checks++; if ({done, error, err_code} !== 4'b0111) begin n_errors++; $display("FAIL abort_status: got %b want 0111", {done, error, err_code}); end
   endtask

   task automatic test_abort_b2();
      int base;
      base = wr_n;
      do_start();
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h01); send_byte(8'h23); send_byte(8'h45, 1'b1);
      finish_stream();
      n_checks++; if (wr_n - base !== 0) begin n_errors++; $display("FAIL abort_b2_writes: got %0d want 0", wr_n - base); end
      n_checks++; if ({done, error, err_code} !== 4'b0111) begin n_errors++; $display("FAIL abort_b2_status: got %b want 0111", {done, error, err_code}); end
   endtask

   task automatic test_start_ignored();
      int base;
      base = wr_n;
      do_start();
      send_byte(8'h00); send_byte(8'h01);
      @(negedge clk);
      bus.in_valid = 1'b0;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
`ifdef PROG_LOADER_CSUM_EN
      send_byte(tb_csum);
`endif
      finish_stream();
      n_checks++; if (wr_n - base !== 1) begin n_errors++; $display("FAIL busy_start_writes: got %0d want 1", wr_n - base); end
      n_checks++; if ({log_addr[base], log_data[base]} !== {8'h00, 19'h00001})
         begin n_errors++; $display("FAIL busy_start_word: got %h/%h want 00/00001", log_addr[base], log_data[base]); end
      n_checks++; if ({done, error, err_code} !== 4'b1000) begin n_errors++; $display("FAIL busy_start_status: got %b want 1000", {done, error, err_code}); end
   endtask

   task automatic test_max_len();
      int base;
      logic [7:0] iv;
      base = wr_n;
      do_start();
      send_byte(8'h01); send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         iv = 8'(i);
         send_byte({5'd0, iv[2:0]}); send_byte(iv); send_byte(~iv);
      end
`ifdef PROG_LOADER_CSUM_EN
      send_byte(tb_csum);
`endif
      finish_stream();
      n_checks++; if (wr_n - base !== 256) begin n_errors++; $display("FAIL max_write_count: got %0d want 256", wr_n - base); end
      for (int i = 0; i < 256; i++) begin
         iv = 8'(i);
         n_checks++;
         if ({log_addr[base+i], log_data[base+i]} !== {iv, iv[2:0], iv, ~iv}) begin
            n_errors++;
            $display("FAIL max_word%0d: got %h/%h want %h/%h", i, log_addr[base+i], log_data[base+i], iv, {iv[2:0], iv, ~iv});
         end
      end
      n_checks++; if ({done, error, err_code} !== 4'b1000) begin n_errors++; $display("FAIL max_status: got %b want 1000", {done, error, err_code}); end
   endtask

`ifdef PROG_LOADER_CSUM_EN
   task automatic test_csum_bad();
      int base;
      base = wr_n;
      do_start();
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
      send_byte(8'h07); send_byte(8'hFF); send_byte(8'hFF);
      send_byte(8'h60);
      finish_stream();
      n_checks++; if (wr_n - base !== 2) begin n_errors++; $display("FAIL csum_bad_writes: got %0d want 2", wr_n - base); end
      n_checks++; if ({done, error, err_code} !== 4'b0111) begin n_errors++; $display("FAIL csum_bad_status: got %b want 0111", {done, error, err_code}); end
   endtask
`endif

   task automatic test_reset_mid();
      int base;
      base = wr_n;
      do_start();
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
      send_byte(8'h07);
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset        = 1'b1;
      #1;
      n_checks++; if ({cpu_hold, bus.in_ready, bus.mem_we} !== 3'b000) begin n_errors++; $display("FAIL reset_mid_outputs: got %b want 000", {cpu_hold, bus.in_ready, bus.mem_we}); end
      n_checks++; if ({bus.mem_addr, done, error, err_code} !== 12'h000) begin n_errors++; $display("FAIL reset_mid_regs: got %h want 000", {bus.mem_addr, done, error, err_code}); end
      n_checks++; if (wr_n - base !== 1) begin n_errors++; $display("FAIL reset_mid_writes: got %0d want 1", wr_n - base); end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if ({cpu_hold, done, error} !== 3'b000) begin n_errors++; $display("FAIL reset_mid_idle: got %b want 000", {cpu_hold, done, error}); end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      test_reset();
      test_two_words();
      test_abort_idle();
      test_len_overflow();
      test_empty();
      test_bad_format();
      test_abort();
      test_abort_b2();
      test_start_ignored();
      test_max_len();
`ifdef PROG_LOADER_CSUM_EN
      test_csum_bad();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
